// File: rtl/prog_clock_divider.sv
// Runtime-programmable clock divider / clock-enable generator.
// Produces a 50% toggle output or a one-cycle pulse every D cycles; divisor/mode updates land at terminal count.
module prog_clock_divider #(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned DEFAULT_DIV  = 1000,
    parameter bit          DEFAULT_MODE = 1'b0
) (
    input  logic             cin,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] div_in,
    input  logic             mode_in,
    input  logic             div_load,
    output logic             cout,
    output logic             tick,
    output logic             pending,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] DefDiv = WIDTH'(DEFAULT_DIV);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] shadow_div_q, shadow_div_d;
    logic             shadow_mode_q, shadow_mode_d;
    logic             pending_q, pending_d;
    logic             cout_q, cout_d;
    logic             tick_q, tick_d;

    logic [WIDTH-1:0] div_eff;
    logic             tc;

    // A programmed divisor of zero behaves as divide-by-one.
    assign div_eff = (div_q == '0) ? WIDTH'(1) : div_q;
    assign tc      = en && (count_q == div_eff - WIDTH'(1));

    always_comb begin
        count_d       = count_q;
        div_d         = div_q;
        mode_d        = mode_q;
        shadow_div_d  = shadow_div_q;
        shadow_mode_d = shadow_mode_q;
        pending_d     = pending_q;
        cout_d        = cout_q;
        tick_d        = 1'b0;

        if (!en) begin
            if (div_load) begin
                // With the counter frozen there is no period to finish, so apply at once.
                div_d     = div_in;
                mode_d    = mode_in;
                count_d   = '0;
                pending_d = 1'b0;
                cout_d    = (mode_q || mode_in) ? 1'b0 : cout_q;
            end else begin
                cout_d = mode_q ? 1'b0 : cout_q;
            end
        end else if (tc) begin
            count_d   = '0;
            tick_d    = 1'b1;
            pending_d = 1'b0;
            if (div_load) begin
                div_d  = div_in;
                mode_d = mode_in;
            end else if (pending_q) begin
                div_d  = shadow_div_q;
                mode_d = shadow_mode_q;
            end
            // Output follows the mode in force from this edge; pulse->toggle restarts low.
            if (mode_d) begin
                cout_d = 1'b1;
            end else if (mode_q) begin
                cout_d = 1'b0;
            end else begin
                cout_d = ~cout_q;
            end
        end else begin
            count_d = count_q + WIDTH'(1);
            cout_d  = mode_q ? 1'b0 : cout_q;
            if (div_load) begin
                shadow_div_d  = div_in;
                shadow_mode_d = mode_in;
                pending_d     = 1'b1;
            end
        end
    end

    always_ff @(posedge cin or negedge rst_n) begin
        if (!rst_n) begin
            count_q       <= '0;
            div_q         <= DefDiv;
            mode_q        <= DEFAULT_MODE;
            shadow_div_q  <= '0;
            shadow_mode_q <= 1'b0;
            pending_q     <= 1'b0;
            cout_q        <= 1'b0;
            tick_q        <= 1'b0;
        end else begin
            count_q       <= count_d;
            div_q         <= div_d;
            mode_q        <= mode_d;
            shadow_div_q  <= shadow_div_d;
            shadow_mode_q <= shadow_mode_d;
            pending_q     <= pending_d;
            cout_q        <= cout_d;
            tick_q        <= tick_d;
        end
    end

    assign cout    = cout_q;
    assign tick    = tick_q;
    assign pending = pending_q;
    assign count   = count_q;

endmodule
